barrel_shift_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter/rotator; generalises the 4-bit combinational circular right shift.

---
 rtl/barrel_shift_pipe_pkg.sv | 27 ++
 rtl/barrel_shift_pipe_shift_stage.sv | 71 +++++++
 rtl/barrel_shift_pipe.sv | 89 ++++++++
 tb/tb_barrel_shift_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shift_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter/rotator:
// operation mode encodings and small helpers used by the top and its stages.
package barrel_shift_pipe_pkg;

    // Operation modes as they appear on the in_mode port.
    typedef enum logic [1:0] {
        MODE_ROR = 2'b00,
        MODE_ROL = 2'b01,
        MODE_LSR = 2'b10,
        MODE_ASR = 2'b11
    } shift_mode_e;

    // Both rotate flavours use the same right-rotate datapath inside a stage.
    function automatic logic isRotate(input shift_mode_e mode);
        return (mode == MODE_ROR) || (mode == MODE_ROL);
    endfunction

    // Left rotation by n is a right rotation by (WIDTH - n) mod WIDTH. Because
    // WIDTH is a power of two, the modulo is the natural wrap of the
    // SH_W-bit shift amount, so two's-complement negation is all it takes.
    function automatic logic [31:0] negateMod(input logic [31:0] amount, input int unsigned shW);
        logic [31:0] mask;
        mask = (32'd1 << shW) - 32'd1;
        return ((~amount) + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/barrel_shift_pipe_shift_stage.sv
// One registered stage of the barrel shifter. The stage applies a fixed
// shift of AMT positions when its own bit of the shift amount is set and
// otherwise passes the data through. The handshake decision (load_i) is made
// by the top, which owns the whole stall chain.
module shift_stage
    import barrel_shift_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT   = 1,
    localparam int SH_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SH_W-1:0]  shamt_i,
    input  shift_mode_e      mode_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [SH_W-1:0]  shamt_o,
    output shift_mode_e      mode_o
);

    // Which bit of the shift amount this stage is responsible for.
    localparam int IDX = $clog2(AMT);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] shifted;
    logic [SH_W-1:0]  shamt_q;
    shift_mode_e      mode_q;

    // Fixed-distance shift for this stage. Arithmetic shifts replicate the
    // current MSB; earlier arithmetic stages never change the MSB, so it
    // still holds the sign bit captured when the beat entered the pipe.
    always_comb begin
        shifted = data_i;
        if (isRotate(mode_i)) begin
            shifted = {data_i[AMT-1:0], data_i[WIDTH-1:AMT]};
        end else if (mode_i == MODE_LSR) begin
            shifted = {{AMT{1'b0}}, data_i[WIDTH-1:AMT]};
        end else begin
            shifted = {{AMT{data_i[WIDTH-1]}}, data_i[WIDTH-1:AMT]};
        end
        data_d = shamt_i[IDX] ? shifted : data_i;
    end

    // Stage register: cleared by reset, otherwise captures the upstream beat
    // (or bubble) whenever the stall chain lets this stage advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= MODE_ROR;
        end else if (load_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            shamt_q <= shamt_i;
            mode_q  <= mode_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign mode_o  = mode_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready on both sides.
// One register stage per shift-amount bit; stage i shifts by 2^i.
// Supports rotate right/left, logical right and arithmetic right.
module barrel_shift_pipe
    import barrel_shift_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SH_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SH_W-1:0]  in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Index 0 is the (pre-processed) input beat, index i+1 is the output
    // register of stage i, so the last entry drives the output port.
    logic [SH_W:0]    chainValid;
    logic [WIDTH-1:0] chainData  [SH_W+1];
    logic [SH_W-1:0]  chainShamt [SH_W+1];
    shift_mode_e      chainMode  [SH_W+1];

    logic [SH_W-1:0]  stageLoad;
    shift_mode_e      inModeEnum;
    logic [SH_W-1:0]  entryShamt;
    shift_mode_e      entryMode;
    logic             unusedTail;

    // Input conditioning: a left rotate is turned into a right rotate by the
    // complementary amount here, so the stages only ever rotate right.
    always_comb begin
        inModeEnum = shift_mode_e'(in_mode);
        entryShamt = in_shamt;
        entryMode  = inModeEnum;
        if (inModeEnum == MODE_ROL) begin
            entryShamt = SH_W'(negateMod(32'(in_shamt), SH_W));
            entryMode  = MODE_ROR;
        end
    end

    assign chainValid[0] = in_valid;
    assign chainData[0]  = in_data;
    assign chainShamt[0] = entryShamt;
    assign chainMode[0]  = entryMode;

    // Stall chain, evaluated from the output backwards: a stage may load when
    // it is empty or when its downstream neighbour is loading (or, for the
    // last stage, draining). Empty stages always load, which collapses bubbles.
    always_comb begin
        stageLoad = '0;
        stageLoad[SH_W-1] = ~chainValid[SH_W] | out_ready;
        for (int i = SH_W - 2; i >= 0; i--) begin
            stageLoad[i] = ~chainValid[i+1] | stageLoad[i+1];
        end
    end

    for (genvar i = 0; i < SH_W; i++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << i)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (stageLoad[i]),
            .valid_i (chainValid[i]),
            .data_i  (chainData[i]),
            .shamt_i (chainShamt[i]),
            .mode_i  (chainMode[i]),
            .valid_o (chainValid[i+1]),
            .data_o  (chainData[i+1]),
            .shamt_o (chainShamt[i+1]),
            .mode_o  (chainMode[i+1])
        );
    end

    assign in_ready  = stageLoad[0];
    assign out_valid = chainValid[SH_W];
    assign out_data  = chainData[SH_W];

    // The last stage's amount and mode have no further consumer.
    assign unusedTail = ^{chainShamt[SH_W], chainMode[SH_W]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Testbench for barrel_shift_pipe: three instances (WIDTH 4, 8, 32) driven
// with directed vectors and random traffic, checked against queues of
// expected results.
module tb_barrel_shift_pipe;

    logic clock = 1'b0;
    logic rstN;

    // WIDTH=4 instance
    logic        inValid4, inReady4, outValid4, outReady4;
    logic [3:0]  inData4, outData4;
    logic [1:0]  inShamt4, inMode4;

    // WIDTH=8 instance
    logic        inValid8, inReady8, outValid8, outReady8;
    logic [7:0]  inData8, outData8;
    logic [2:0]  inShamt8;
    logic [1:0]  inMode8;

    // WIDTH=32 instance
    logic        inValid32, inReady32, outValid32, outReady32;
    logic [31:0] inData32, outData32;
    logic [4:0]  inShamt32;
    logic [1:0]  inMode32;

    int checkCount = 0;
    int errorCount = 0;
    int acceptCount4 = 0, acceptCount8 = 0, acceptCount32 = 0;
    string curTag = "init";

    logic [31:0] expQ4[$];
    logic [31:0] expQ8[$];
    logic [31:0] expQ32[$];

    logic [31:0] d;
    int          sh;
    logic [1:0]  m;
    int          startAccepts;
    logic        staleSeen;

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    barrel_shift_pipe #(.WIDTH(4)) dut4 (
        .clk(clock), .rst_n(rstN), .in_valid(inValid4), .in_ready(inReady4),
        .in_data(inData4), .in_shamt(inShamt4), .in_mode(inMode4),
        .out_valid(outValid4), .out_ready(outReady4), .out_data(outData4)
    );

    barrel_shift_pipe #(.WIDTH(8)) dut8 (
        .clk(clock), .rst_n(rstN), .in_valid(inValid8), .in_ready(inReady8),
        .in_data(inData8), .in_shamt(inShamt8), .in_mode(inMode8),
        .out_valid(outValid8), .out_ready(outReady8), .out_data(outData8)
    );

    barrel_shift_pipe #(.WIDTH(32)) dut32 (
        .clk(clock), .rst_n(rstN), .in_valid(inValid32), .in_ready(inReady32),
        .in_data(inData32), .in_shamt(inShamt32), .in_mode(inMode32),
        .out_valid(outValid32), .out_ready(outReady32), .out_data(outData32)
    );

    // Bit-by-bit reference: each result bit is looked up at its source position.
    function automatic logic [31:0] refShift(input logic [31:0] data, input int amount,
                                             input logic [1:0] mode, input int w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < w; k++) begin
            case (mode)
                2'b00:   r[k] = data[(k + amount) % w];
                2'b01:   r[k] = data[(k - amount + w) % w];
                2'b10:   r[k] = (k + amount < w) ? data[k + amount] : 1'b0;
                default: r[k] = (k + amount < w) ? data[k + amount] : data[w-1];
            endcase
        end
        return r;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s/%s observed=%0h expected=%0h", curTag, tag, observed, expected);
        end
    endtask

    // One clock of traffic on the 8-bit instance: checks a draining beat
    // against the queue head and queues the caller's expected value if the
    // current input beat is accepted.
    task automatic applyStimulus8(input logic [31:0] expIfAccepted);
        #1;
        if (outValid8 && outReady8) begin
            if (expQ8.size() == 0) checkOutput("w8_unexpected_beat", 32'd1, 32'd0);
            else checkOutput("w8_data", 32'(outData8), expQ8.pop_front());
        end
        if (inValid8 && inReady8) begin
            expQ8.push_back(expIfAccepted);
            acceptCount8++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus4(input logic [31:0] expIfAccepted);
        #1;
        if (outValid4 && outReady4) begin
            if (expQ4.size() == 0) checkOutput("w4_unexpected_beat", 32'd1, 32'd0);
            else checkOutput("w4_data", 32'(outData4), expQ4.pop_front());
        end
        if (inValid4 && inReady4) begin
            expQ4.push_back(expIfAccepted);
            acceptCount4++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus32(input logic [31:0] expIfAccepted);
        #1;
        if (outValid32 && outReady32) begin
            if (expQ32.size() == 0) checkOutput("w32_unexpected_beat", 32'd1, 32'd0);
            else checkOutput("w32_data", outData32, expQ32.pop_front());
        end
        if (inValid32 && inReady32) begin
            expQ32.push_back(expIfAccepted);
            acceptCount32++;
        end
        @(posedge clock);
        #1;
    endtask

    // Bounded drains: stop feeding, let everything out, then require an empty queue.
    task automatic drain8();
        inValid8 = 1'b0;
        outReady8 = 1'b1;
        for (int n = 0; n < 40 && expQ8.size() > 0; n++) applyStimulus8(32'd0);
        checkOutput("w8_left_in_flight", 32'(expQ8.size()), 32'd0);
    endtask

    task automatic drain4();
        inValid4 = 1'b0;
        outReady4 = 1'b1;
        for (int n = 0; n < 40 && expQ4.size() > 0; n++) applyStimulus4(32'd0);
        checkOutput("w4_left_in_flight", 32'(expQ4.size()), 32'd0);
    endtask

    task automatic drain32();
        inValid32 = 1'b0;
        outReady32 = 1'b1;
        for (int n = 0; n < 40 && expQ32.size() > 0; n++) applyStimulus32(32'd0);
        checkOutput("w32_left_in_flight", 32'(expQ32.size()), 32'd0);
    endtask

    // Load the 8-bit instance inputs with a directed vector.
    task automatic setIn8(input logic [7:0] data, input logic [2:0] amount, input logic [1:0] mode);
        inData8 = data;
        inShamt8 = amount;
        inMode8 = mode;
    endtask

    // Load the 8-bit instance inputs with a random vector and return its model result.
    task automatic randIn8(output logic [31:0] expected);
        d  = $urandom & 32'hFF;
        sh = int'($urandom_range(0, 7));
        m  = 2'($urandom_range(0, 3));
        inData8 = d[7:0];
        inShamt8 = 3'(sh);
        inMode8 = m;
        expected = refShift(d, sh, m, 8);
    endtask

    // Watchdog so the run always ends on its own.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main test sequence.
    initial begin
        logic [31:0] e;
        rstN = 1'b0;
        inValid4 = 0; outReady4 = 1; inData4 = '0; inShamt4 = '0; inMode4 = '0;
        inValid8 = 0; outReady8 = 1; inData8 = '0; inShamt8 = '0; inMode8 = '0;
        inValid32 = 0; outReady32 = 1; inData32 = '0; inShamt32 = '0; inMode32 = '0;
        repeat (3) @(posedge clock);
        #1;
        curTag = "reset";
        checkOutput("out_valid8", 32'(outValid8), 32'd0);
        checkOutput("out_data8", 32'(outData8), 32'd0);
        checkOutput("out_valid4", 32'(outValid4), 32'd0);
        checkOutput("out_valid32", 32'(outValid32), 32'd0);
        rstN = 1'b1;
        #1;
        checkOutput("in_ready8", 32'(inReady8), 32'd1);

        // WIDTH=4 rotate right of 1011 by every amount, then the other modes.
        curTag = "t1_w4";
        inValid4 = 1'b1; inData4 = 4'b1011; inMode4 = 2'b00;
        inShamt4 = 2'd0; applyStimulus4(32'hB);
        inShamt4 = 2'd1; applyStimulus4(32'hD);
        inShamt4 = 2'd2; applyStimulus4(32'hE);
        inShamt4 = 2'd3; applyStimulus4(32'h7);
        inMode4 = 2'b01; inShamt4 = 2'd1; applyStimulus4(32'h7);
        inMode4 = 2'b01; inShamt4 = 2'd0; applyStimulus4(32'hB);
        inData4 = 4'b1000; inMode4 = 2'b10; inShamt4 = 2'd3; applyStimulus4(32'h1);
        inData4 = 4'b1000; inMode4 = 2'b11; inShamt4 = 2'd3; applyStimulus4(32'hF);
        drain4();

        // WIDTH=8 directed mode vectors, including shamt 0 and WIDTH-1.
        curTag = "t2_w8";
        inValid8 = 1'b1;
        setIn8(8'h81, 3'd1, 2'b01); applyStimulus8(32'h03);
        setIn8(8'h80, 3'd7, 2'b10); applyStimulus8(32'h01);
        setIn8(8'h80, 3'd3, 2'b11); applyStimulus8(32'hF0);
        setIn8(8'hA5, 3'd0, 2'b11); applyStimulus8(32'hA5);
        setIn8(8'hA5, 3'd0, 2'b01); applyStimulus8(32'hA5);
        setIn8(8'h01, 3'd7, 2'b00); applyStimulus8(32'h02);
        setIn8(8'h01, 3'd7, 2'b01); applyStimulus8(32'h80);
        setIn8(8'h7F, 3'd7, 2'b11); applyStimulus8(32'h00);
        setIn8(8'hFF, 3'd4, 2'b10); applyStimulus8(32'h0F);
        setIn8(8'hC3, 3'd1, 2'b11); applyStimulus8(32'hE1);
        drain8();

        // 16 back-to-back beats; first result appears 3 cycles after the first accept.
        curTag = "t3_stream";
        startAccepts = acceptCount8;
        inValid8 = 1'b1;
        outReady8 = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            randIn8(e);
            applyStimulus8(e);
            if (n <= 3) checkOutput("latency", 32'(outValid8), (n == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("accepted", 32'(acceptCount8 - startAccepts), 32'd16);
        drain8();

        // Consumer stalls for 10 cycles under continuous input.
        curTag = "t4_stall";
        startAccepts = acceptCount8;
        inValid8 = 1'b1;
        outReady8 = 1'b0;
        for (int n = 0; n < 10; n++) begin
            randIn8(e);
            applyStimulus8(e);
            if (outValid8 && expQ8.size() > 0) checkOutput("hold", 32'(outData8), expQ8[0]);
        end
        checkOutput("accepted", 32'(acceptCount8 - startAccepts), 32'd3);
        checkOutput("in_ready_low", 32'(inReady8), 32'd0);
        checkOutput("out_valid", 32'(outValid8), 32'd1);
        outReady8 = 1'b1;
        randIn8(e);
        #1;
        checkOutput("full_pass_ready", 32'(inReady8), 32'd1);
        applyStimulus8(e);
        drain8();
        checkOutput("accepted_total", 32'(acceptCount8 - startAccepts), 32'd4);

        // Reset with two beats in flight discards them.
        curTag = "t5_reset";
        inValid8 = 1'b1;
        outReady8 = 1'b1;
        randIn8(e); applyStimulus8(e);
        randIn8(e); applyStimulus8(e);
        inValid8 = 1'b0;
        outReady8 = 1'b0;
        rstN = 1'b0;
        applyStimulus8(32'd0);
        checkOutput("out_valid", 32'(outValid8), 32'd0);
        checkOutput("out_data", 32'(outData8), 32'd0);
        rstN = 1'b1;
        expQ8.delete();
        #1;
        checkOutput("in_ready", 32'(inReady8), 32'd1);
        outReady8 = 1'b1;
        staleSeen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            applyStimulus8(32'd0);
            staleSeen = staleSeen | outValid8;
        end
        checkOutput("no_stale", 32'(staleSeen), 32'd0);

        // Random traffic with random backpressure on every width.
        curTag = "t6_w8";
        for (int n = 0; n < 300; n++) begin
            inValid8 = 1'($urandom_range(0, 1));
            outReady8 = 1'($urandom_range(0, 1));
            randIn8(e);
            applyStimulus8(e);
        end
        drain8();

        curTag = "t6_w4";
        for (int n = 0; n < 300; n++) begin
            inValid4 = 1'($urandom_range(0, 1));
            outReady4 = 1'($urandom_range(0, 1));
            d  = $urandom & 32'hF;
            sh = int'($urandom_range(0, 3));
            m  = 2'($urandom_range(0, 3));
            inData4 = d[3:0];
            inShamt4 = 2'(sh);
            inMode4 = m;
            applyStimulus4(refShift(d, sh, m, 4));
        end
        drain4();

        curTag = "t6_w32";
        for (int n = 0; n < 300; n++) begin
            inValid32 = 1'($urandom_range(0, 1));
            outReady32 = 1'($urandom_range(0, 1));
            d  = $urandom;
            sh = int'($urandom_range(0, 31));
            m  = 2'($urandom_range(0, 3));
            inData32 = d;
            inShamt32 = 5'(sh);
            inMode32 = m;
            applyStimulus32(refShift(d, sh, m, 32));
        end
        drain32();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
